spi_slave_byte: RTL
===================

# spi_slave_byte

SPI responder-side byte transceiver: the far end of the SD-card SPI master shifter, used to emulate an SD card or external SPI peripheral on the bench and as a slave port for the SoC. It oversamples an external SPI bus on MasterCLK in mode 3 (CPOL=1, CPHA=1, MSB first), receives one MOSI byte per 8 clocks, and shifts out a byte from a one-entry transmit buffer on MISO. The system-side interface is a single-cycle valid pulse for receive and a ready/load handshake for transmit.

## Interface
- FILL, 8'hFF, byte sent on MISO when the transmit buffer is empty at byte start (SD idle pattern)
- SYNC_STAGES, 2, synchronizer flops on SPI_CLK, SPI_MOSI, SPI_CS_n (min 2)
- MasterCLK  input  1  system clock; all logic on its rising edge
- Reset  input  1  synchronous, active-high reset
- SPI_CLK  input  1  SPI clock from master, idles high
- SPI_MOSI  input  1  master-out data
- SPI_CS_n  input  1  chip select, active low
- SPI_MISO  output  1  slave-out data; 1 when not selected
- SPI_MISO_OE  output  1  MISO drive enable; 1 only while selected
- TxData  input  8  byte to send next
- TxLoad  input  1  one-cycle write strobe for TxData
- TxReady  output  1  transmit buffer empty
- TxUnderrun  output  1  one-cycle pulse: byte started with empty buffer, FILL sent
- RxData  output  8  last complete received byte; held until next
- RxValid  output  1  one-cycle pulse: RxData updated

## Operation
- Reset: SPI_MISO=1, SPI_MISO_OE=0, TxReady=1, TxUnderrun=0, RxData=8'h00, RxValid=0, bit counter=0, buffer empty, synchronizer history set to idle (CLK=1, CS_n=1).
- Inputs pass through SYNC_STAGES flops; one further register gives previous value; rise/fall of SPI_CLK and CS_n detected from synchronized values only.
- States: IDLE (CS_n high) and ACTIVE (CS_n low).
- IDLE: bit counter=0, OE=0, MISO=1, SPI_CLK edges ignored. Synchronized CS_n fall -> ACTIVE, OE=1.
- ACTIVE, SPI_CLK fall with counter=0: load tx shift register from buffer (buffer -> empty, TxReady=1 next cycle) or FILL if empty (TxUnderrun pulse); drive bit 7 on MISO.
- ACTIVE, SPI_CLK fall with counter 1..7: drive next bit (bit 7-counter).
- ACTIVE, SPI_CLK rise: shift synchronized MOSI into rx shift register LSB, counter+1; on counter 7->0 wrap, RxData <= assembled byte, RxValid=1 one cycle.
- Synchronized CS_n rise in any state -> IDLE: partial rx byte discarded (no RxValid), counter=0, OE=0, MISO=1. A byte already moved to the tx shift register is lost; buffer contents not yet loaded are kept.
- TxLoad with TxReady=1: TxData captured, TxReady=0 next cycle. TxLoad with TxReady=0: ignored, buffer unchanged.
- TxLoad in the same cycle as a byte-start fall with empty buffer: FILL sent, TxUnderrun pulses, TxData captured for the following byte (TxReady=0).
- CS_n fall and SPI_CLK edge detected in the same cycle: CS_n processed first; edge acted on in ACTIVE.
- Back-to-back bytes: no gap required; byte N+1 starts at the 9th falling edge.

## Timing
- Pin-to-detection latency: SYNC_STAGES+1 MasterCLK cycles.
- MISO/OE update: registered, 1 cycle after detection (4 cycles after pin edge at default).
- RxValid: asserted 1 cycle after detection of 8th rising edge; high exactly 1 cycle.
- TxReady rises the cycle after the consuming fall is detected.
- SPI_CLK high and low phases each at least SYNC_STAGES+4 MasterCLK cycles; CS_n setup to first SPI_CLK fall the same. Faster SPI_CLK is out of spec.

## Test plan
- Reset held 3 cycles, bus idle -> MISO=1, OE=0, TxReady=1, RxValid=0, RxData=8'h00.
- TxLoad 8'hA5, CS_n low, master sends 8'h3C at SPI_CLK = MasterCLK/16 -> master samples 8'hA5 on MISO; one RxValid with RxData=8'h3C; TxReady back to 1 after first fall.
- No TxLoad, master clocks 8'h00 -> MISO shows 8'hFF, TxUnderrun pulses once, RxData=8'h00.
- Three back-to-back bytes 8'h01,8'h80,8'hFF with TxLoad 8'h11,8'h22,8'h33 issued on each TxReady -> three RxValid pulses in order, MISO sequence 11,22,33, no TxUnderrun.
- CS_n raised after 5 bits, then new 8-bit transfer of 8'h5A -> no RxValid for partial byte; single RxValid with 8'h5A; OE=0 while CS_n high.
- TxLoad 8'h12 then TxLoad 8'h34 before consumption -> 8'h12 transmitted, 8'h34 ignored; TxLoad coincident with byte-start on empty buffer -> FILL sent, loaded byte sent next.

Source files
------------

// File: rtl/spi_slave_byte_if.sv
// SPI pin bundle plus the system-side transmit/receive handshake of the byte transceiver.
// Pure wiring: no storage, no latency.
// Transmit uses TxReady/TxLoad; receive is an unthrottled RxValid pulse.
interface spi_slave_byte_if;
    logic       SPI_CLK;
    logic       SPI_MOSI;
    logic       SPI_CS_n;
    logic       SPI_MISO;
    logic       SPI_MISO_OE;
    logic [7:0] TxData;
    logic       TxLoad;
    logic       TxReady;
    logic       TxUnderrun;
    logic [7:0] RxData;
    logic       RxValid;

    modport slave (
        input  SPI_CLK, SPI_MOSI, SPI_CS_n, TxData, TxLoad,
        output SPI_MISO, SPI_MISO_OE, TxReady, TxUnderrun, RxData, RxValid
    );

    modport master (
        output SPI_CLK, SPI_MOSI, SPI_CS_n, TxData, TxLoad,
        input  SPI_MISO, SPI_MISO_OE, TxReady, TxUnderrun, RxData, RxValid
    );
endinterface

// File: rtl/spi_slave_byte.sv
// SPI mode-3 responder: oversamples SPI pins, receives MOSI bytes, shifts out a one-entry tx buffer.
// Latency: pin edge -> detect SYNC_STAGES+1 cycles, MISO/OE/RxValid registered one cycle later.
// Backpressure: TxLoad ignored while TxReady=0; empty buffer at byte start sends FILL (TxUnderrun).
module spi_slave_byte #(
    parameter logic [7:0] FILL        = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic MasterCLK,
    input  logic Reset,
    spi_slave_byte_if.slave bus
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic                   clk_prev;
    logic                   cs_prev;
    logic                   s_clk;
    logic                   s_cs;
    logic                   s_mosi;
    logic                   clk_fall;
    logic                   clk_rise;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   act;
    logic                   byte_start;

    logic                   miso;
    logic                   oe;
    logic                   buf_full;
    logic [7:0]             buf_dat;
    logic [7:0]             tx_sr;
    logic [7:0]             tx_next;
    logic [6:0]             rx_sr;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_dat;
    logic                   rx_vld;
    logic                   underrun;

    assign s_clk    = clk_sr[SYNC_STAGES-1];
    assign s_cs     = cs_sr[SYNC_STAGES-1];
    assign s_mosi   = mosi_sr[SYNC_STAGES-1];
    assign clk_fall = clk_prev & ~s_clk;
    assign clk_rise = ~clk_prev & s_clk;
    assign cs_fall  = cs_prev & ~s_cs;
    assign cs_rise  = ~cs_prev & s_cs;
    assign tx_next  = buf_full ? buf_dat : FILL;

    // Synchronize the asynchronous SPI pins and keep one cycle of history for edge detection.
    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            clk_sr   <= '1;
            cs_sr    <= '1;
            mosi_sr  <= '1;
            clk_prev <= 1'b1;
            cs_prev  <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], bus.SPI_CLK};
            cs_sr    <= {cs_sr[SYNC_STAGES-2:0], bus.SPI_CS_n};
            mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], bus.SPI_MOSI};
            clk_prev <= s_clk;
            cs_prev  <= s_cs;
        end
    end

    // Select state register.
    always_ff @(posedge MasterCLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state from chip-select edges; an SPI_CLK edge in the entry cycle already counts as active.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        act        = (state_nxt == ACTIVE);
        byte_start = act & clk_fall & (bit_cnt == 3'd0);
    end

    // Transmit buffer, shift registers, bit counter and registered outputs.
    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            miso     <= 1'b1;
            oe       <= 1'b0;
            buf_full <= 1'b0;
            buf_dat  <= 8'h00;
            tx_sr    <= 8'h00;
            rx_sr    <= 7'h00;
            bit_cnt  <= 3'd0;
            rx_dat   <= 8'h00;
            rx_vld   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            rx_vld   <= 1'b0;
            underrun <= 1'b0;
            // A load into an empty buffer is taken even when the same cycle starts a byte with FILL.
            if (bus.TxLoad && !buf_full) begin
                buf_full <= 1'b1;
                buf_dat  <= bus.TxData;
            end else if (byte_start && buf_full) begin
                buf_full <= 1'b0;
            end
            if (!act) begin
                bit_cnt <= 3'd0;
                oe      <= 1'b0;
                miso    <= 1'b1;
            end else begin
                oe <= 1'b1;
                if (clk_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_sr    <= tx_next;
                        miso     <= tx_next[7];
                        underrun <= ~buf_full;
                    end else begin
                        miso <= tx_sr[3'd7 - bit_cnt];
                    end
                end
                if (clk_rise) begin
                    rx_sr   <= {rx_sr[5:0], s_mosi};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_dat <= {rx_sr, s_mosi};
                        rx_vld <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.SPI_MISO    = miso;
    assign bus.SPI_MISO_OE = oe;
    assign bus.TxReady     = ~buf_full;
    assign bus.TxUnderrun  = underrun;
    assign bus.RxData      = rx_dat;
    assign bus.RxValid     = rx_vld;

endmodule
